// File: rtl/bru_pkg.sv
// Shared types for the branch resolve unit: FSM states, prediction-queue
// entry layout and err_sticky bit positions.
package bru_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    WAIT  = 2'd2
  } bru_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } bru_entry_t;

  localparam int ERR_OVERFLOW    = 0;
  localparam int ERR_UNDERFLOW   = 1;
  localparam int ERR_PC_MISMATCH = 2;
  localparam int ERR_W           = 3;

endpackage

// File: rtl/bru_pred_fifo.sv
// Circular prediction queue with extra-MSB pointers, synchronous clear and
// sticky overflow/underflow flags (cleared only by reset).
module bru_pred_fifo
  import bru_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  bru_entry_t push_data,
  input  logic       pop,
  input  logic       clear,
  output bru_entry_t head,
  output logic       full,
  output logic       empty,
  output logic       overflow,
  output logic       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  bru_entry_t  mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A simultaneous pop frees the slot, so push is accepted even when full.
  assign do_pop  = pop && !empty && !clear;
  assign do_push = push && !clear && (!full || do_pop);

  assign head = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (!clear) begin
      if (push && full && !pop) overflow  <= 1'b1;
      if (pop && empty)         underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: queues fetch predictions, checks them against ID
// outcomes, issues flush/redirect and predictor training. Optional macro
// BRU_STATS_EN adds saturating branch/mispredict counters.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int FALLTHRU_OFF = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        pred_valid,
  input  logic [31:0] pred_pc,
  input  logic        pred_taken,
  input  logic [31:0] pred_target,
  input  logic        res_valid,
  input  logic [31:0] res_pc,
  input  logic        res_is_branch,
  input  logic        res_taken,
  input  logic [31:0] res_target,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        upd_valid,
  output logic [31:0] upd_pc,
  output logic        upd_taken,
  output logic [31:0] upd_target,
  output logic        q_full,
  output logic [2:0]  err_sticky
`ifdef BRU_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
`endif
);

  bru_state_e state_q;
  bru_state_e state_d;

  logic        push_en;
  logic        pop_en;
  logic        clear_en;

  bru_entry_t  push_entry;
  bru_entry_t  fifo_head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_overflow;
  logic        fifo_underflow;

  logic [31:0] fallthru_pc;
  logic        head_taken;
  logic [31:0] head_target;
  logic        pc_mismatch;
  logic        mispredict;
  logic [31:0] redirect_calc;

  logic        flush_p1;
  logic        redir_vld_p1;
  logic [31:0] redir_pc_p1;
  logic        vld_p1;
  logic [31:0] upd_pc_p1;
  logic        upd_taken_p1;
  logic [31:0] upd_target_p1;
  logic        pc_err_p1;

  assign push_entry = '{pc: pred_pc, taken: pred_taken, target: pred_target};

  bru_pred_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RESET),
    .push      (push_en),
    .push_data (push_entry),
    .pop       (pop_en),
    .clear     (clear_en),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .overflow  (fifo_overflow),
    .underflow (fifo_underflow)
  );

  // ---- stage p0: compare resolved outcome against queue head ----
  assign fallthru_pc = res_pc + 32'(FALLTHRU_OFF);

  // An empty queue behaves as a not-taken prediction to the fall-through.
  always_comb begin
    head_taken  = fifo_head.taken;
    head_target = fifo_head.target;
    if (fifo_empty) begin
      head_taken  = 1'b0;
      head_target = fallthru_pc;
    end
  end

  assign pc_mismatch   = !fifo_empty && (fifo_head.pc != res_pc);
  assign mispredict    = pc_mismatch
                       || (res_is_branch && (res_taken != head_taken))
                       || (res_is_branch && res_taken && (res_target != head_target))
                       || (!res_is_branch && head_taken);
  assign redirect_calc = res_taken ? res_target : fallthru_pc;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    push_en  = 1'b0;
    pop_en   = 1'b0;
    clear_en = 1'b0;
    if (!STALL) begin
      unique case (state_q)
        RUN: begin
          push_en = pred_valid;
          pop_en  = res_valid;
          if (res_valid && mispredict) state_d = FLUSH;
        end
        FLUSH: begin
          clear_en = 1'b1;
          state_d  = WAIT;
        end
        WAIT: begin
          // Squashed bubbles may still resolve here; only the refetch ends WAIT.
          push_en = pred_valid;
          if (pred_valid && (pred_pc == redir_pc_p1)) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // ---- stage p1: registered flush/redirect and training outputs ----
  always_ff @(posedge CLK) begin
    if (RESET) begin
      flush_p1      <= 1'b0;
      redir_vld_p1  <= 1'b0;
      redir_pc_p1   <= '0;
      vld_p1        <= 1'b0;
      upd_pc_p1     <= '0;
      upd_taken_p1  <= 1'b0;
      upd_target_p1 <= '0;
      pc_err_p1     <= 1'b0;
    end else begin
      flush_p1     <= pop_en && mispredict;
      redir_vld_p1 <= pop_en && mispredict;
      vld_p1       <= pop_en && res_is_branch;
      if (pop_en && mispredict) redir_pc_p1 <= redirect_calc;
      if (pop_en && res_is_branch) begin
        upd_pc_p1     <= res_pc;
        upd_taken_p1  <= res_taken;
        upd_target_p1 <= res_target;
      end
      if (pop_en && pc_mismatch) pc_err_p1 <= 1'b1;
    end
  end

  assign flush          = flush_p1;
  assign redirect_valid = redir_vld_p1;
  assign redirect_pc    = redir_pc_p1;
  assign upd_valid      = vld_p1;
  assign upd_pc         = upd_pc_p1;
  assign upd_taken      = upd_taken_p1;
  assign upd_target     = upd_target_p1;
  assign q_full         = fifo_full;

  assign err_sticky[ERR_OVERFLOW]    = fifo_overflow;
  assign err_sticky[ERR_UNDERFLOW]   = fifo_underflow;
  assign err_sticky[ERR_PC_MISMATCH] = pc_err_p1;

`ifdef BRU_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // ---- stage p2: statistics follow the registered strobes ----
  always_ff @(posedge CLK) begin
    if (RESET) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (vld_p1)   stat_branches    <= sat_inc(stat_branches);
      if (flush_p1) stat_mispredicts <= sat_inc(stat_mispredicts);
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Tracks every in-flight fetch prediction from fetch through the seven-stage IF-to-ID delay pipeline.
- Compares each prediction against the actual outcome that ID resolves.
- On a mismatch, issues a one-cycle flush and a corrected redirect PC to IF, and sends a training update to the branch predictor.
- Sits beside the predictor: the predictor produces predictions, this block consumes outcomes.

Parameters:
- DEPTH, 8, prediction-queue entries; power of two, at least the IF-to-ID stage count plus 1.
- FALLTHRU_OFF, 8, byte offset from the branch PC to the not-taken path (accounts for the delay slot).

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- STALL  in  1  pipeline freeze from ID; blocks enqueue and resolve.
- pred_valid  in  1  IF emitted an instruction this cycle.
- pred_pc  in  32  PC of that instruction.
- pred_taken  in  1  predictor said taken.
- pred_target  in  32  predicted target.
- res_valid  in  1  ID resolved an instruction this cycle.
- res_pc  in  32  PC of the resolved instruction.
- res_is_branch  in  1  instruction is a branch or jump.
- res_taken  in  1  actual direction.
- res_target  in  32  actual target.
- flush  out  1  squash IF-to-ID stages.
- redirect_valid  out  1  IF must load redirect_pc.
- redirect_pc  out  32  corrected fetch address.
- upd_valid  out  1  predictor training strobe.
- upd_pc  out  32  branch PC for training.
- upd_taken  out  1  actual direction for training.
- upd_target  out  32  actual target for training.
- q_full  out  1  queue full; IF must hold.
- err_sticky  out  3  {pc_mismatch, underflow, overflow}.

Behaviour:
- Reset: all outputs 0, queue empty, state RUN. RESET in the middle of a flush or wait abandons it immediately.
- Queue: a circular FIFO with log2(DEPTH)+1-bit pointers; pointers wrap modulo DEPTH.
  - Enqueue happens when pred_valid && !STALL && state!=FLUSH.
  - Pop happens when res_valid && !STALL && state==RUN.
  - Enqueue and pop in the same cycle are allowed even when full; count is unchanged.
  - Enqueue while full and not popping: entry dropped, err_sticky[0] set.
- Pop while empty: treat as predicted not-taken with pred_target=res_pc+FALLTHRU_OFF, and set err_sticky[1].
- Popped head PC != res_pc: set err_sticky[2] and treat it as a mispredict.
- Mispredict is any of:
  - res_is_branch and res_taken != pred_taken;
  - res_is_branch, res_taken, and res_target != pred_target;
  - !res_is_branch and pred_taken.
- Outputs are registered; latency is 1 cycle after the resolve cycle.
  - upd_valid pulses for every popped entry with res_is_branch=1.
  - upd_taken and upd_target carry the actual outcome.
  - On a mispredict, flush and redirect_valid pulse for exactly 1 cycle.
  - redirect_pc = res_taken ? res_target : res_pc+FALLTHRU_OFF, computed in 32-bit arithmetic with no carry-out kept.
- States:
  - RUN: normal operation. A mispredict moves to FLUSH.
  - FLUSH: lasts 1 cycle. flush=1, redirect_valid=1, queue cleared, and any enqueue this cycle is dropped (flush wins). Always moves to WAIT.
  - WAIT: resolves are ignored (no pop, no update), because squashed bubbles may still arrive. Enqueues are accepted. Moves to RUN in the cycle after an enqueue with pred_pc==redirect_pc.
- STALL=1: state, queue and pointers all hold; output pulses are not generated.
- err_sticky bits clear only on RESET.

Optional Feature:
- Macro: BRU_STATS_EN.
- When defined, adds outputs stat_branches [31:0] and stat_mispredicts [31:0].
  - stat_branches increments on each upd_valid.
  - stat_mispredicts increments on each flush.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package bru_pkg holds:
  - state enum {RUN, FLUSH, WAIT};
  - entry struct {pc[31:0], taken, target[31:0]};
  - err bit-index constants.
- One sub-module, bru_pred_fifo: parameterised queue with push, pop, clear, full/empty and sticky overflow/underflow.
- The top level holds the compare logic and the FSM.

Test Plan:
- Correct prediction:
  - Enqueue pc=0x400, taken=1, target=0x500.
  - Resolve 0x400, branch, taken, target 0x500.
  - Expect: next cycle upd_valid=1, upd_target=0x500; flush=0.
- Direction mispredict:
  - Enqueue 0x400 predicted not-taken.
  - Resolve taken to 0x480.
  - Expect: flush=1 and redirect_pc=0x480 for 1 cycle, queue empty, state WAIT.
  - Then enqueue 0x480: next cycle state=RUN.
- False-taken non-branch:
  - Enqueue 0x410 with taken=1.
  - Resolve 0x410 with res_is_branch=0.
  - Expect: flush=1, redirect_pc=0x418, upd_valid=0.
- Full/wrap:
  - Push 8 entries: q_full=1.
  - Push and pop together for 20 cycles: no err bits set, FIFO order preserved.
  - Push again without a pop: err_sticky[0]=1.
- Stall and reset:
  - Assert STALL with res_valid=1: no pop, no output pulse.
  - Assert RESET in WAIT: state=RUN and all outputs 0 next cycle.
- BRU_STATS_EN defined:
  - Resolve 3 branches with 1 mispredict.
  - Expect: stat_branches=3, stat_mispredicts=1.
